// File: rtl/tone_sequencer.sv
// Tone sequencer: a bus-programmed FIFO of {freq, duration} notes played out
// as a frequency word, with durations counted in prescaled ticks.
module tone_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned GAP_TICKS  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  output logic [31:0] freq_out,
  output logic        busy,
  output logic        irq
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  state_t state_q, state_d;

  logic [31:0]   mem_freq [FIFO_DEPTH];
  logic [15:0]   mem_dur  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   staged_freq_q, cur_freq_q, presc_q;
  logic [15:0]   cur_dur_q, tick_cnt_q;
  logic          enable_q, irq_en_q, done_q, overflow_q;

  logic [4:0]  sel;
  logic        bus_wr, bus_rd, wr_freq, wr_dur, wr_ctrl, wr_stat;
  logic        flush, en_eff, fifo_full, fifo_empty, more, tick;
  logic        pop, pop_ok, push_ok, push_drop, done_set, note_end;
  logic [15:0] head_dur;
  logic [31:0] count_ext, status_word;
  logic [3:0]  count_sat;
  logic        unused_addr;

  assign sel         = addr[4:0];
  assign unused_addr = ^addr[31:5];
  assign bus_wr      = cs & wr;
  assign bus_rd      = cs & rd;
  assign wr_freq     = bus_wr && (sel == 5'h00);
  assign wr_dur      = bus_wr && (sel == 5'h04);
  assign wr_ctrl     = bus_wr && (sel == 5'h08);
  assign wr_stat     = bus_wr && (sel == 5'h0C);
  assign flush       = wr_ctrl & d_in[1];
  // A CTRL write takes effect on the FSM in the same cycle it is issued.
  assign en_eff      = wr_ctrl ? d_in[0] : enable_q;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head_dur   = mem_dur[rd_ptr_q];
  assign tick       = (presc_q == TICK_LAST);
  // In LOAD the head entry is leaving, so only the remainder counts.
  assign more       = (state_q == LOAD) ? (count_q > CW'(1)) : !fifo_empty;

  assign pop_ok    = pop & !fifo_empty;
  assign push_ok   = wr_dur & !flush & (!fifo_full | pop_ok);
  assign push_drop = wr_dur & !flush & fifo_full & !pop_ok;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    done_set = 1'b0;
    note_end = 1'b0;
    unique case (state_q)
      IDLE: if (en_eff && !fifo_empty) state_d = LOAD;
      LOAD: begin
        pop = 1'b1;
        if (head_dur != '0)     state_d = PLAY;
        else if (GAP_TICKS != 0) state_d = GAP;
        else                     note_end = 1'b1;
      end
      PLAY: if (tick && (tick_cnt_q == cur_dur_q - 16'd1)) begin
        if (GAP_TICKS != 0) state_d = GAP;
        else                note_end = 1'b1;
      end
      GAP: if (tick && (tick_cnt_q == GAP_LAST)) note_end = 1'b1;
      default: state_d = IDLE;
    endcase
    if (note_end) begin
      if (more) state_d = LOAD;
      else begin
        state_d  = IDLE;
        done_set = 1'b1;
      end
    end
    if (flush || (state_q != IDLE && !en_eff)) begin
      state_d  = IDLE;
      pop      = 1'b0;
      done_set = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_freq[wr_ptr_q] <= staged_freq_q;
      mem_dur[wr_ptr_q]  <= d_in[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
        else if (!push_ok && pop_ok) count_q <= count_q - CW'(1);
      end
      if (push_drop)                overflow_q <= 1'b1;
      else if (wr_stat && d_in[9])  overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staged_freq_q <= '0;
      enable_q      <= 1'b0;
      irq_en_q      <= 1'b0;
      done_q        <= 1'b0;
      cur_freq_q    <= '0;
      cur_dur_q     <= '0;
      presc_q       <= '0;
      tick_cnt_q    <= '0;
    end else begin
      if (wr_freq) staged_freq_q <= d_in;
      if (wr_ctrl) begin
        enable_q <= d_in[0];
        irq_en_q <= d_in[2];
      end
      if (done_set)                done_q <= 1'b1;
      else if (wr_stat && d_in[8]) done_q <= 1'b0;
      if (state_q == LOAD) begin
        cur_freq_q <= mem_freq[rd_ptr_q];
        cur_dur_q  <= head_dur;
        presc_q    <= '0;
        tick_cnt_q <= '0;
      end else if (state_q == PLAY || state_q == GAP) begin
        if (tick) begin
          presc_q    <= '0;
          tick_cnt_q <= (state_d != state_q) ? '0 : tick_cnt_q + 16'd1;
        end else begin
          presc_q <= presc_q + 32'd1;
        end
      end
    end
  end

  assign freq_out = (state_q == PLAY) ? cur_freq_q : '0;
  assign busy     = (state_q != IDLE);
  assign irq      = done_q & irq_en_q;

  assign count_ext = 32'(count_q);
  assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

  always_comb begin
    status_word      = '0;
    status_word[0]   = busy;
    status_word[1]   = fifo_full;
    status_word[2]   = fifo_empty;
    status_word[7:4] = count_sat;
    status_word[8]   = done_q;
    status_word[9]   = overflow_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out <= '0;
    end else if (bus_rd) begin
      unique case (sel)
        5'h08:   d_out <= {29'd0, irq_en_q, 1'b0, enable_q};
        5'h0C:   d_out <= status_word;
        5'h10:   d_out <= freq_out;
        default: d_out <= '0;
      endcase
    end else begin
      d_out <= '0;
    end
  end
endmodule
